hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 51 +++++
 rtl/hazard_ctrl_sat_counter.sv | 39 +++
 rtl/hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_hazard_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  hazard_ctrl_pkg : shared pipeline constants for the hazard controller
//  Revision: 1.0
// ============================================================================
package hazard_ctrl_pkg;

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    // Numeric order doubles as priority: higher value wins.
    typedef enum logic [1:0] {
        HZ_NONE     = 2'd0,
        HZ_LOAD_USE = 2'd1,
        HZ_FLUSH    = 2'd2,
        HZ_FREEZE   = 2'd3
    } hazard_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic exmem_write;
        logic ifid_flush;
        logic idex_bubble;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, ifid_write: 1'b1,
        idex_write: 1'b1, exmem_write: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0};
    localparam stage_ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0,
        idex_write: 1'b0, exmem_write: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b0};
    localparam stage_ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, ifid_write: 1'b1,
        idex_write: 1'b1, exmem_write: 1'b1, ifid_flush: 1'b1, idex_bubble: 1'b1};
    localparam stage_ctrl_t CTRL_LOAD_USE = '{pc_write: 1'b0, ifid_write: 1'b0,
        idex_write: 1'b1, exmem_write: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b1};

    // Only a load result can't be forwarded in time; x0 is hardwired zero.
    function automatic logic load_use_hit(
        input logic       memread,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       uses_rs1,
        input logic       uses_rs2
    );
        return memread && (rd != 5'd0) &&
               ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  sat_counter : up-counter with synchronous clear that sticks at all-ones
//  Revision: 1.0
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  hazard_ctrl : pipeline stall/flush/freeze control with memory-wait timeout
//  Revision: 1.0
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       idex_rd,
    input  logic             idex_memread,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int               TMR_W   = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] timer_d;
    logic             mem_err_q;
    logic             mem_err_d;

    logic             freeze;
    logic             load_use;
    hazard_e          hazard;
    stage_ctrl_t      ctrl;

    always_comb begin
        freeze   = ((state_q == ST_RUN) && mem_req && !mem_ready) ||
                   ((state_q == ST_MEM_WAIT) && !mem_ready);
        load_use = load_use_hit(idex_memread, idex_rd, id_rs1, id_rs2,
                                id_uses_rs1, id_uses_rs2);

        // A branch seen while frozen is simply re-evaluated once unfrozen,
        // since EX is held and keeps ex_branch_taken asserted.
        if (freeze) begin
            hazard = HZ_FREEZE;
        end else if (ex_branch_taken) begin
            hazard = HZ_FLUSH;
        end else if (load_use) begin
            hazard = HZ_LOAD_USE;
        end else begin
            hazard = HZ_NONE;
        end

        case (hazard)
            HZ_FREEZE:   ctrl = CTRL_FREEZE;
            HZ_FLUSH:    ctrl = CTRL_FLUSH;
            HZ_LOAD_USE: ctrl = CTRL_LOAD_USE;
            default:     ctrl = CTRL_NORMAL;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:      if (mem_req && !mem_ready) state_d = ST_MEM_WAIT;
            ST_MEM_WAIT: if (mem_ready)             state_d = ST_RUN;
            default:                                state_d = ST_RUN;
        endcase

        timer_d = '0;
        if (freeze) begin
            timer_d = (timer_q == TMR_MAX) ? timer_q : timer_q + 1'b1;
        end

        mem_err_d = mem_err_q || (timer_d == TMR_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            timer_q   <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            mem_err_q <= mem_err_d;
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (1'b0),
        .inc   ((hazard == HZ_FREEZE) || (hazard == HZ_LOAD_USE)),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (1'b0),
        .inc   (hazard == HZ_FLUSH),
        .count (flush_cnt)
    );

    assign pc_write    = ctrl.pc_write;
    assign ifid_write  = ctrl.ifid_write;
    assign idex_write  = ctrl.idex_write;
    assign exmem_write = ctrl.exmem_write;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_bubble = ctrl.idex_bubble;
    assign mem_err     = mem_err_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_hazard_ctrl : directed scenarios plus random traffic vs. reference model
//  Revision: 1.0
// ============================================================================
module tb_hazard_ctrl;

    localparam int TB_TIMEOUT = 64;
    localparam int TB_CNT_W   = 4;
    localparam int CNT_MAX    = (1 << TB_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [4:0]          id_rs1, id_rs2, idex_rd;
    logic                id_uses_rs1, id_uses_rs2, idex_memread;
    logic                ex_branch_taken, mem_req, mem_ready;
    logic                pc_write, ifid_write, idex_write, exmem_write;
    logic                ifid_flush, idex_bubble, mem_err;
    logic [TB_CNT_W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_wait, m_err;
    int m_stall, m_flush, m_streak;
    bit e_frz, e_fl, e_lu;

    hazard_ctrl #(.TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .idex_rd         (idex_rd),
        .idex_memread    (idex_memread),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .idex_write      (idex_write),
        .exmem_write     (exmem_write),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .mem_err         (mem_err),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; idex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; idex_memread = 1'b0;
        ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic model_reset();
        m_wait = 1'b0; m_err = 1'b0;
        m_stall = 0; m_flush = 0; m_streak = 0;
    endtask

    // One clock: check decode mid-cycle, advance model at the edge, check state after.
    task automatic run_cycle(input string tag);
        bit raw_lu;
        @(negedge clk);
        raw_lu = idex_memread && (idex_rd != 0) &&
                 ((id_uses_rs1 && id_rs1 == idex_rd) || (id_uses_rs2 && id_rs2 == idex_rd));
        e_frz = m_wait ? !mem_ready : (mem_req && !mem_ready);
        e_fl  = !e_frz && ex_branch_taken;
        e_lu  = !e_frz && !e_fl && raw_lu;
        chk({tag, "_pc_write"},    pc_write,    !e_frz && !e_lu);
        chk({tag, "_ifid_write"},  ifid_write,  !e_frz && !e_lu);
        chk({tag, "_idex_write"},  idex_write,  !e_frz);
        chk({tag, "_exmem_write"}, exmem_write, !e_frz);
        chk({tag, "_ifid_flush"},  ifid_flush,  e_fl);
        chk({tag, "_idex_bubble"}, idex_bubble, e_fl || e_lu);
        chk({tag, "_state"},       dut.state_q, m_wait);
        @(posedge clk);
        m_streak = e_frz ? m_streak + 1 : 0;
        if (m_streak >= TB_TIMEOUT) m_err = 1'b1;
        if (e_frz || e_lu) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
        if (e_fl) m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
        m_wait = e_frz;
        #1;
        chk({tag, "_stall_cnt"}, stall_cnt, m_stall);
        chk({tag, "_flush_cnt"}, flush_cnt, m_flush);
        chk({tag, "_mem_err"},   mem_err,   m_err);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        #7;
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        chk("rst_mem_err",   mem_err,   0);
        chk("rst_pc_write",  pc_write,  1);
        rst_n = 1'b1;

        // Load-use on rs1
        idex_memread = 1'b1; idex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        run_cycle("lu");
        chk("lu_stall_total", stall_cnt, 1);
        idle();
        run_cycle("lu_after");

        // Same but x0: no stall
        idex_memread = 1'b1; idex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
        run_cycle("lu_x0");
        chk("lu_x0_stall_total", stall_cnt, 1);
        idle();

        // Three-cycle memory wait
        mem_req = 1'b1;
        for (int i = 0; i < 3; i++) run_cycle("mw");
        mem_ready = 1'b1;
        run_cycle("mw_done");
        chk("mw_stall_total", stall_cnt, 4);
        idle();

        // Branch deferred across a 2-cycle freeze
        mem_req = 1'b1; ex_branch_taken = 1'b1;
        for (int i = 0; i < 2; i++) run_cycle("brfrz");
        mem_ready = 1'b1;
        run_cycle("brfrz_rel");
        chk("brfrz_flush_total", flush_cnt, 1);
        idle();

        // Branch with simultaneous load-use: flush only
        ex_branch_taken = 1'b1;
        idex_memread = 1'b1; idex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
        run_cycle("br_lu");
        chk("br_lu_stall_total", stall_cnt, 6);
        chk("br_lu_flush_total", flush_cnt, 2);
        idle();

        // Timeout after TIMEOUT consecutive wait cycles
        mem_req = 1'b1;
        for (int i = 0; i < TB_TIMEOUT; i++) begin
            run_cycle("tmo");
            if (i == TB_TIMEOUT - 2) chk("tmo_err_early", mem_err, 0);
        end
        chk("tmo_err_set", mem_err, 1);
        chk("tmo_stall_sat", stall_cnt, CNT_MAX);
        mem_ready = 1'b1;
        run_cycle("tmo_ready");
        chk("tmo_err_sticky", mem_err, 1);

        // Reset in the middle of a wait
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) run_cycle("rstw");
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstw_state",     dut.state_q, 0);
        chk("rstw_pc_write",  pc_write,    1);
        chk("rstw_stall_cnt", stall_cnt,   0);
        chk("rstw_flush_cnt", flush_cnt,   0);
        chk("rstw_mem_err",   mem_err,     0);
        model_reset();
        rst_n = 1'b1;

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            idex_rd         = 5'($urandom_range(0, 3));
            id_uses_rs1     = 1'($urandom_range(0, 1));
            id_uses_rs2     = 1'($urandom_range(0, 1));
            idex_memread    = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            mem_req         = ($urandom_range(0, 3) == 0);
            mem_ready       = ($urandom_range(0, 4) < 3);
            run_cycle("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
